// File: rtl/mmio_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_io_pkg
// Description : Register map offsets, window size and a clog2 helper shared
//               by the memory-mapped I/O controller and its debounce channels.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_io_pkg;

    // Input channel registers always start at the bottom of the window.
    localparam int IN_OFS = 0;

    // Ceiling log2 evaluated at elaboration time; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int out_ofs(input int in_ch);
        return IN_OFS + in_ch;
    endfunction

    function automatic int status_ofs(input int in_ch, input int out_ch);
        return IN_OFS + in_ch + out_ch;
    endfunction

    function automatic int mask_ofs(input int in_ch, input int out_ch);
        return status_ofs(in_ch, out_ch) + 1;
    endfunction

    // Number of word addresses claimed by the controller.
    function automatic int window_size(input int in_ch, input int out_ch);
        return in_ch + out_ch + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : io_debounce
// Description : One input channel: multi-flop synchroniser followed by a
//               whole-channel debouncer. change_pulse is high in the cycle
//               whose rising edge commits a new stable value.
// Revision    : 1.0 - initial release
// ============================================================================
module io_debounce
    import mmio_io_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] stable,
    output logic             change_pulse
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_cand;
    logic [WIDTH-1:0]                  r_stable;
    logic [CNT_W-1:0]                  r_cnt;
    logic [WIDTH-1:0]                  w_sync_out;
    logic                              w_settled;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Candidate has held long enough and differs from the committed value.
    assign w_settled = (w_sync_out == r_cand) && (r_cand != r_stable) &&
                       (r_cnt == c_cnt_last);

    // Shift the asynchronous pins through the synchroniser chain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
        end
    end

    // Track a candidate value; any bounce restarts the stability count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cand   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else if (w_sync_out != r_cand) begin
            r_cand <= w_sync_out;
            r_cnt  <= '0;
        end else if (r_cand != r_stable) begin
            if (r_cnt == c_cnt_last) begin
                r_stable <= r_cand;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign stable       = r_stable;
    assign change_pulse = w_settled;

endmodule
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmio_io_ctrl
// Description : Memory-mapped I/O block on the dmem bus. Debounced input
//               channels, writable output registers, sticky W1C change
//               status, interrupt mask and a combinational read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_io_ctrl
    import mmio_io_pkg::*;
#(
    parameter int               BASE_ADDR       = 4096,
    parameter int               WIDTH           = 16,
    parameter int               IN_CH           = 2,
    parameter int               OUT_CH          = 2,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             address,
    input  logic                    wren,
    input  logic [31:0]             data_in,
    output logic                    io_hit,
    output logic [31:0]             q_io,
    input  logic [IN_CH*WIDTH-1:0]  pins_in,
    output logic [OUT_CH*WIDTH-1:0] pins_out,
    output logic                    irq
);

    localparam logic [31:0] c_base       = 32'(BASE_ADDR);
    localparam logic [31:0] c_out_ofs    = 32'(out_ofs(IN_CH));
    localparam logic [31:0] c_status_ofs = 32'(status_ofs(IN_CH, OUT_CH));
    localparam logic [31:0] c_mask_ofs   = 32'(mask_ofs(IN_CH, OUT_CH));
    localparam logic [31:0] c_window     = 32'(window_size(IN_CH, OUT_CH));

    logic [31:0]                   w_ofs;
    logic                          w_hit;
    logic                          w_wr;
    logic                          w_status_wr;
    logic                          w_mask_wr;
    logic [IN_CH-1:0]              w_clear;
    logic [IN_CH-1:0][WIDTH-1:0]   w_in_stable;
    logic [IN_CH-1:0]              w_change;
    logic [31:0]                   w_q;
    logic                          w_unused;

    logic [OUT_CH-1:0][WIDTH-1:0]  r_out;
    logic [IN_CH-1:0]              r_status;
    logic [IN_CH-1:0]              r_mask;

    // Addresses below the base wrap to huge offsets and miss the window.
    assign w_ofs       = address - c_base;
    assign w_hit       = (w_ofs < c_window);
    assign w_wr        = wren && w_hit;
    assign w_status_wr = w_wr && (w_ofs == c_status_ofs);
    assign w_mask_wr   = w_wr && (w_ofs == c_mask_ofs);
    assign w_clear     = w_status_wr ? data_in[IN_CH-1:0] : '0;

    // Upper write-data bits are intentionally dropped for narrow registers.
    assign w_unused = ^data_in;

    generate
        for (genvar i = 0; i < IN_CH; i++) begin : g_in_ch
            io_debounce #(
                .WIDTH           (WIDTH),
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock        (clock),
                .reset        (reset),
                .pin          (pins_in[i*WIDTH +: WIDTH]),
                .stable       (w_in_stable[i]),
                .change_pulse (w_change[i])
            );
        end
    endgenerate

    // Output registers load the low WIDTH bits of the write data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out <= {OUT_CH{OUT_RESET}};
        end else if (w_wr) begin
            for (int j = 0; j < OUT_CH; j++) begin
                if (w_ofs == c_out_ofs + 32'(j)) begin
                    r_out[j] <= data_in[WIDTH-1:0];
                end
            end
        end
    end

    // Sticky change bits: clear first, then OR in new events so a set wins.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_clear) | w_change;
        end
    end

    // Interrupt enable mask.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mask <= '0;
        end else if (w_mask_wr) begin
            r_mask <= data_in[IN_CH-1:0];
        end
    end

    // Zero-extended read mux; every compare fails outside the window.
    always_comb begin
        w_q = '0;
        for (int i = 0; i < IN_CH; i++) begin
            if (w_ofs == 32'(IN_OFS + i)) begin
                w_q[WIDTH-1:0] = w_in_stable[i];
            end
        end
        for (int j = 0; j < OUT_CH; j++) begin
            if (w_ofs == c_out_ofs + 32'(j)) begin
                w_q[WIDTH-1:0] = r_out[j];
            end
        end
        if (w_ofs == c_status_ofs) begin
            w_q[IN_CH-1:0] = r_status;
        end
        if (w_ofs == c_mask_ofs) begin
            w_q[IN_CH-1:0] = r_mask;
        end
    end

    assign io_hit   = w_hit;
    assign q_io     = w_q;
    assign pins_out = r_out;
    assign irq      = |(r_status & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_io_ctrl
// Description : Self-checking bench for mmio_io_ctrl with a queue of expected
//               values pushed at stimulus time and popped at observation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_io_ctrl;

    localparam int          WIDTH  = 16;
    localparam int          IN_CH  = 2;
    localparam int          OUT_CH = 2;
    localparam logic [31:0] BASE   = 32'd4096;

    logic                    clock   = 1'b0;
    logic                    reset   = 1'b0;
    logic [31:0]             address = '0;
    logic                    wren    = 1'b0;
    logic [31:0]             data_in = '0;
    logic                    io_hit;
    logic [31:0]             q_io;
    logic [IN_CH*WIDTH-1:0]  pins_in = '0;
    logic [OUT_CH*WIDTH-1:0] pins_out;
    logic                    irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    mmio_io_ctrl #(
        .BASE_ADDR       (4096),
        .WIDTH           (WIDTH),
        .IN_CH           (IN_CH),
        .OUT_CH          (OUT_CH),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .OUT_RESET       (16'h00A5)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .wren     (wren),
        .data_in  (data_in),
        .io_hit   (io_hit),
        .q_io     (q_io),
        .pins_in  (pins_in),
        .pins_out (pins_out),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a);
        address = a;
        #1;
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        address = a;
        data_in = d;
        wren    = 1'b1;
        tick(1);
        wren    = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        pins_in = 32'hFFFF_FFFF;
        address = BASE + 2;
        data_in = 32'h0000_1234;
        wren    = 1'b1;
        tick(4);
        exp_q.push_back(32'h00A5_00A5);
        exp = exp_q.pop_front(); checks++;
        if (pins_out !== exp) begin errors++; $display("FAIL reset_pins_out got %h expected %h", pins_out, exp); end
        wren = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2 || k == 3) continue;
            exp_q.push_back(32'h0);
            rd(BASE + 32'(k));
            exp = exp_q.pop_front(); checks++;
            if (q_io !== exp) begin errors++; $display("FAIL reset_reg%0d got %h expected %h", k, q_io, exp); end
        end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, irq} !== exp) begin errors++; $display("FAIL reset_irq got %b expected %h", irq, exp); end
        pins_in = '0;
        tick(4);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_clean_input();
        pins_in[15:0] = 16'h1234;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_1234);
        tick(6);
        rd(BASE);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL clean_in0_edge6 got %h expected %h", q_io, exp); end
        tick(1);
        rd(BASE);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL clean_in0_edge7 got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h1);
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL clean_status got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, irq} !== exp) begin errors++; $display("FAIL clean_irq got %b expected %h", irq, exp); end
    endtask

    task automatic test_bounce();
        write_reg(BASE + 4, 32'h3);
        exp_q.push_back(32'h0);
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL bounce_status_cleared got %h expected %h", q_io, exp); end
        for (int seg = 0; seg < 10; seg++) begin
            pins_in[31:16] = (seg % 2 == 0) ? 16'hFFFF : 16'h0000;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                exp_q.push_back(32'h0);
                rd(BASE + 1);
                exp = exp_q.pop_front(); checks++;
                if (q_io !== exp) begin errors++; $display("FAIL bounce_in1_seg%0d got %h expected %h", seg, q_io, exp); end
            end
        end
        exp_q.push_back(32'h0);
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL bounce_status_toggling got %h expected %h", q_io, exp); end
        pins_in[31:16] = 16'hFFFF;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_FFFF);
        tick(6);
        rd(BASE + 1);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL bounce_in1_edge6 got %h expected %h", q_io, exp); end
        tick(1);
        rd(BASE + 1);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL bounce_in1_edge7 got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h2);
        tick(5);
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL bounce_status got %h expected %h", q_io, exp); end
    endtask

    task automatic test_outputs();
        exp_q.push_back(32'h00A5_BEEF);
        exp_q.push_back(32'h0000_BEEF);
        write_reg(BASE + 2, 32'h0000_BEEF);
        exp = exp_q.pop_front(); checks++;
        if (pins_out !== exp) begin errors++; $display("FAIL out0_pins got %h expected %h", pins_out, exp); end
        rd(BASE + 2);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL out0_read got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h5A5A_BEEF);
        exp_q.push_back(32'h0000_5A5A);
        write_reg(BASE + 3, 32'hFFFF_5A5A);
        exp = exp_q.pop_front(); checks++;
        if (pins_out !== exp) begin errors++; $display("FAIL out1_pins got %h expected %h", pins_out, exp); end
        rd(BASE + 3);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL out1_read got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h0000_1234);
        exp_q.push_back(32'h5A5A_BEEF);
        write_reg(BASE, 32'h0000_FFFF);
        rd(BASE);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL in0_write_ignored got %h expected %h", q_io, exp); end
        exp = exp_q.pop_front(); checks++;
        if (pins_out !== exp) begin errors++; $display("FAIL in_write_pins got %h expected %h", pins_out, exp); end
    endtask

    task automatic test_irq_w1c();
        pins_in[15:0] = 16'h4321;
        exp_q.push_back(32'h3);
        tick(7);
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL irq_status_both got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, irq} !== exp) begin errors++; $display("FAIL irq_unmasked got %b expected %h", irq, exp); end
        exp_q.push_back(32'h1);
        write_reg(BASE + 5, 32'h3);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, irq} !== exp) begin errors++; $display("FAIL irq_masked_on got %b expected %h", irq, exp); end
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h1);
        write_reg(BASE + 4, 32'h1);
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL w1c_bit0 got %h expected %h", q_io, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, irq} !== exp) begin errors++; $display("FAIL irq_after_w1c got %b expected %h", irq, exp); end
        exp_q.push_back(32'h0);
        write_reg(BASE + 5, 32'h1);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, irq} !== exp) begin errors++; $display("FAIL irq_mask_clear got %b expected %h", irq, exp); end
        write_reg(BASE + 4, 32'h2);
        pins_in[31:16] = 16'h0F0F;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h0000_0F0F);
        tick(6);
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL setwin_before got %h expected %h", q_io, exp); end
        data_in = 32'h2;
        wren    = 1'b1;
        tick(1);
        wren    = 1'b0;
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL setwin_status got %h expected %h", q_io, exp); end
        rd(BASE + 1);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL setwin_in1 got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h1);
        write_reg(BASE + 5, 32'h3);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, irq} !== exp) begin errors++; $display("FAIL irq_rearm got %b expected %h", irq, exp); end
    endtask

    task automatic test_decode();
        logic [31:0] outside [2];
        outside[0] = BASE - 1;
        outside[1] = BASE + 6;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            rd(outside[k]);
            exp = exp_q.pop_front(); checks++;
            if ({31'h0, io_hit} !== exp) begin errors++; $display("FAIL decode_hit_out%0d got %b expected %h", k, io_hit, exp); end
            exp = exp_q.pop_front(); checks++;
            if (q_io !== exp) begin errors++; $display("FAIL decode_q_out%0d got %h expected %h", k, q_io, exp); end
            write_reg(outside[k], 32'hFFFF_FFFF);
        end
        exp_q.push_back(32'h1);
        rd(BASE + 5);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, io_hit} !== exp) begin errors++; $display("FAIL decode_hit_mask got %b expected %h", io_hit, exp); end
        exp_q.push_back(32'h3);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL decode_mask_kept got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h2);
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL decode_status_kept got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h5A5A_BEEF);
        exp = exp_q.pop_front(); checks++;
        if (pins_out !== exp) begin errors++; $display("FAIL decode_pins_kept got %h expected %h", pins_out, exp); end
    endtask

    task automatic test_reset_mid_debounce();
        pins_in[15:0] = 16'h1111;
        tick(4);
        reset   = 1'b0;
        address = BASE + 2;
        data_in = 32'h0000_7777;
        wren    = 1'b1;
        tick(1);
        reset = 1'b1;
        wren  = 1'b0;
        exp_q.push_back(32'h00A5_00A5);
        exp = exp_q.pop_front(); checks++;
        if (pins_out !== exp) begin errors++; $display("FAIL midrst_pins got %h expected %h", pins_out, exp); end
        exp_q.push_back(32'h0);
        rd(BASE);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL midrst_in0 got %h expected %h", q_io, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, irq} !== exp) begin errors++; $display("FAIL midrst_irq got %b expected %h", irq, exp); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_1111);
        exp_q.push_back(32'h0000_0F0F);
        exp_q.push_back(32'h3);
        tick(6);
        rd(BASE);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL midrst_in0_early got %h expected %h", q_io, exp); end
        tick(1);
        rd(BASE);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL midrst_in0_settled got %h expected %h", q_io, exp); end
        rd(BASE + 1);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL midrst_in1_settled got %h expected %h", q_io, exp); end
        rd(BASE + 4);
        exp = exp_q.pop_front(); checks++;
        if (q_io !== exp) begin errors++; $display("FAIL midrst_status got %h expected %h", q_io, exp); end
    endtask

    initial begin
        test_reset();
        test_clean_input();
        test_bounce();
        test_outputs();
        test_irq_w1c();
        test_decode();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
